// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide controller.
// Holds architectural HI/LO, computes results into shadow registers when a
// MULT/MULTU/DIV/DIVU starts, and commits them after a fixed countdown.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        start
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_next;
    logic [31:0]      hi_next;
    logic [31:0]      lo_next;
    logic [31:0]      res_hi;
    logic [31:0]      res_hi_next;
    logic [31:0]      res_lo;
    logic [31:0]      res_lo_next;

    logic [0:0]       state;
    logic             is_start_op;
    logic [CNT_W-1:0] op_cycles;
    logic [63:0]      op_res;
    logic [63:0]      keep_val;

    logic             signed_div;
    logic             div_zero;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_b_safe;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;

    // The countdown is the state: nonzero count means an operation is in flight.
    assign state       = busy ? ST_RUN : ST_IDLE;
    assign is_start_op = (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
    assign start       = is_start_op && !busy;

    // Result datapath: one shared magnitude divider serves both DIV and DIVU.
    always_comb begin
        signed_div = (mdOp == OP_DIV);
        div_zero   = (srcB == 32'd0);
        div_a      = (signed_div && srcA[31]) ? (~srcA + 32'd1) : srcA;
        div_b      = (signed_div && srcB[31]) ? (~srcB + 32'd1) : srcB;
        div_b_safe = div_zero ? 32'd1 : div_b;
        q_mag      = div_a / div_b_safe;
        r_mag      = div_a % div_b_safe;
        quot       = (signed_div && (srcA[31] ^ srcB[31])) ? (~q_mag + 32'd1) : q_mag;
        rem        = (signed_div && srcA[31]) ? (~r_mag + 32'd1) : r_mag;
        prod_s     = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prod_u     = {32'd0, srcA} * {32'd0, srcB};
    end

    // Divide-by-zero keeps HI/LO; on a back-to-back start the "prior" value is
    // the result being committed on this same edge.
    assign keep_val = (state == ST_RUN) ? {res_hi, res_lo} : {hi, lo};

    // Select the shadow result and busy duration for the incoming command.
    always_comb begin
        op_res    = keep_val;
        op_cycles = CNT_W'(DIV_CYCLES);
        case (mdOp)
            OP_MULT: begin
                op_res    = prod_s;
                op_cycles = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                op_res    = prod_u;
                op_cycles = CNT_W'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                op_res = div_zero ? keep_val : {rem, quot};
            end
            default: begin
                op_res = keep_val;
            end
        endcase
    end

    // Next-state logic: accept commands in IDLE, count down and commit in RUN.
    always_comb begin
        cnt_next    = cnt;
        busy_next   = busy;
        hi_next     = hi;
        lo_next     = lo;
        res_hi_next = res_hi;
        res_lo_next = res_lo;
        case (state)
            ST_IDLE: begin
                if (is_start_op) begin
                    res_hi_next = op_res[63:32];
                    res_lo_next = op_res[31:0];
                    cnt_next    = op_cycles;
                    busy_next   = 1'b1;
                end else if (mdOp == OP_MTHI) begin
                    hi_next = srcA;
                end else if (mdOp == OP_MTLO) begin
                    lo_next = srcA;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    hi_next   = res_hi;
                    lo_next   = res_lo;
                    cnt_next  = '0;
                    busy_next = 1'b0;
                    // A start arriving on the completion edge chains with no gap.
                    if (is_start_op) begin
                        res_hi_next = op_res[63:32];
                        res_lo_next = op_res[31:0];
                        cnt_next    = op_cycles;
                        busy_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                cnt_next  = '0;
                busy_next = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            cnt    <= cnt_next;
            busy   <= busy_next;
            hi     <= hi_next;
            lo     <= lo_next;
            res_hi <= res_hi_next;
            res_lo <= res_lo_next;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed scoreboard bench for mdu_ctrl.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        start;

    int          errors;
    int          checks;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic [63:0] exp_q[$];

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mdOp (mdOp),
        .srcA (srcA),
        .srcB (srcB),
        .busy (busy),
        .hi   (hi),
        .lo   (lo),
        .start(start)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one command for one edge; check start while it is applied.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_start);
        @(negedge clk);
        mdOp = op;
        srcA = a;
        srcB = b;
        #1;
        check("start", 32'(start), 32'(exp_start));
        @(posedge clk);
        #1;
        mdOp = 3'd0;
    endtask

    // Called just after a start edge: count busy cycles, check HI/LO hold,
    // then pop the scoreboard and compare the committed result.
    task automatic wait_done(input string tag, input int n, input bit inject);
        int c;
        logic [63:0] e;
        c = 1;
        while (busy === 1'b1 && c <= 40) begin
            check({tag, " hi hold"}, hi, cur_hi);
            check({tag, " lo hold"}, lo, cur_lo);
            if (inject && c == 2)      step(3'd6, 32'h0000DEAD, 32'd0, 1'b0);
            else if (inject && c == 3) step(3'd1, 32'd7, 32'd7, 1'b0);
            else                       step(3'd0, 32'd0, 32'd0, 1'b0);
            c++;
        end
        check({tag, " busy cycles"}, 32'(c - 1), 32'(n));
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " hi"}, hi, e[63:32]);
            check({tag, " lo"}, lo, e[31:0]);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
        end
    endtask

    initial begin
        logic [63:0] e;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        mdOp   = 3'd0;
        srcA   = 32'd0;
        srcB   = 32'd0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset start idle", 32'(start), 32'd0);
        mdOp = 3'd1;
        #1;
        check("reset start comb", 32'(start), 32'd1);
        mdOp = 3'd0;
        @(negedge clk);
        reset = 1'b0;

        // MTHI / MTLO
        step(3'd5, 32'h12345678, 32'd0, 1'b0);
        check("mthi hi", hi, 32'h12345678);
        check("mthi busy", 32'(busy), 32'd0);
        step(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0);
        check("mtlo lo", lo, 32'h9ABCDEF0);
        check("mtlo hi", hi, 32'h12345678);
        check("mtlo busy", 32'(busy), 32'd0);
        cur_hi = 32'h12345678;
        cur_lo = 32'h9ABCDEF0;

        // MULT signed and MULTU
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        step(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        wait_done("mult", 5, 1'b0);
        exp_q.push_back({32'h00000002, 32'hFFFFFFFA});
        step(3'd2, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        wait_done("multu", 5, 1'b0);

        // DIV signed with DIVU chained on its completion edge
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        step(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            check("div busy", 32'(busy), 32'd1);
            check("div hi hold", hi, cur_hi);
            check("div lo hold", lo, cur_lo);
            step(3'd0, 32'd0, 32'd0, 1'b0);
        end
        check("div busy last", 32'(busy), 32'd1);
        exp_q.push_back({32'h00000001, 32'h00000003});
        step(3'd4, 32'd7, 32'd2, 1'b0);
        e = exp_q.pop_front();
        check("div hi", hi, e[63:32]);
        check("div lo", lo, e[31:0]);
        check("divu chained busy", 32'(busy), 32'd1);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
        wait_done("divu", 10, 1'b0);

        // DIV overflow case
        exp_q.push_back({32'h00000000, 32'h80000000});
        step(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done("div ovf", 10, 1'b0);

        // DIVU by zero keeps HI/LO
        step(3'd5, 32'hAAAA0000, 32'd0, 1'b0);
        step(3'd6, 32'h00005555, 32'd0, 1'b0);
        check("pre div0 hi", hi, 32'hAAAA0000);
        check("pre div0 lo", lo, 32'h00005555);
        cur_hi = 32'hAAAA0000;
        cur_lo = 32'h00005555;
        exp_q.push_back({32'hAAAA0000, 32'h00005555});
        step(3'd4, 32'd1234, 32'd0, 1'b1);
        wait_done("divu0", 10, 1'b0);

        // Commands while busy are ignored
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        step(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        wait_done("mult inj", 5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(3'd0, 32'd0, 32'd0, 1'b0);
            check("post inj busy", 32'(busy), 32'd0);
            check("post inj hi", hi, 32'hFFFFFFFF);
            check("post inj lo", lo, 32'hFFFFFFFA);
        end

        // Reset during busy cycle 3 of a DIV
        step(3'd3, 32'd100, 32'd7, 1'b1);
        step(3'd0, 32'd0, 32'd0, 1'b0);
        step(3'd0, 32'd0, 32'd0, 1'b0);
        check("pre rst busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(3'd0, 32'd0, 32'd0, 1'b0);
            check("after rst busy", 32'(busy), 32'd0);
            check("after rst hi", hi, 32'd0);
            check("after rst lo", lo, 32'd0);
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
